// File: rtl/pong_pkg.sv
// Shared Pong definitions: FSM state encoding, score and tick-counter widths.
// Also used by the ball logic, so keep encodings stable.
package pong_pkg;

   localparam int SCORE_W = 4;
   localparam int TICK_W  = 8;

   localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_SERVE = 3'd1,
      ST_PLAY  = 3'd2,
      ST_POINT = 3'd3,
      ST_OVER  = 3'd4
   } state_t;

   // Score increment that sticks at the top of the score range.
   function automatic logic [SCORE_W-1:0] score_inc(input logic [SCORE_W-1:0] s);
      return (s == SCORE_MAX) ? s : s + SCORE_W'(1);
   endfunction

endpackage

// File: rtl/game_controller_if.sv
// Signal bundle between the game controller and the rest of the Pong system.
// There is no valid/ready handshake on this bus: frame_tick, p1_miss and
// p2_miss are single-cycle pulses that are acted on in the cycle they are
// high, start_btn is a synchronised level, and every controller output is a
// register that changes the cycle after the event that causes it.
interface game_controller_if;
   import pong_pkg::*;

   logic               frame_tick;
   logic               start_btn;
   logic               p1_miss;
   logic               p2_miss;
   logic               reset_game;
   logic               ball_en;
   logic               serve_dir;
   logic [SCORE_W-1:0] score1;
   logic [SCORE_W-1:0] score2;
   logic [1:0]         winner;
   logic [2:0]         state;

   // Game-side view: drives the events, observes the controller.
   modport master (
      output frame_tick, start_btn, p1_miss, p2_miss,
      input  reset_game, ball_en, serve_dir, score1, score2, winner, state
   );

   // Controller view.
   modport slave (
      input  frame_tick, start_btn, p1_miss, p2_miss,
      output reset_game, ball_en, serve_dir, score1, score2, winner, state
   );

endinterface

// File: rtl/tick_timer.sv
// Clearable frame-tick counter with a terminal-count compare.
// A tick in the first cycle after a clear (the first cycle of a new state)
// is not counted, so every timed state waits for full ticks of its own.
module tick_timer
   import pong_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              clear,
   input  logic              tick,
   input  logic [TICK_W-1:0] target,
   output logic              done
);

   logic [TICK_W-1:0] count;
   logic              fresh;
   logic              counted;

   assign counted = tick && !fresh;

   // Count accepted ticks; a clear restarts the count and marks the next cycle fresh.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count <= '0;
         fresh <= 1'b0;
      end else begin
         fresh <= clear;
         if (clear) begin
            count <= '0;
         end else if (counted && count != '1) begin
            count <= count + TICK_W'(1);
         end
      end
   end

   // Terminal count: this accepted tick is the target-th since the clear.
   assign done = counted && (({1'b0, count} + 9'd1) == {1'b0, target});

endmodule

// File: rtl/game_controller.sv
// Pong game controller: start/serve/play/point/game-over sequencing and
// score keeping. All outputs are registered from the next-state decode.
module game_controller
   import pong_pkg::*;
#(
   parameter int WIN_SCORE   = 7,
   parameter int SERVE_TICKS = 30,
   parameter int PAUSE_TICKS = 60
) (
   input logic              clk,
   input logic              reset,
   game_controller_if.slave bus
);

   localparam logic [SCORE_W-1:0] WIN_S     = SCORE_W'(WIN_SCORE);
   localparam logic [TICK_W-1:0]  SERVE_TGT = TICK_W'(SERVE_TICKS);
   localparam logic [TICK_W-1:0]  PAUSE_TGT = TICK_W'(PAUSE_TICKS);

   state_t             state_q, state_d;
   logic               start_q;
   logic               start_rise;
   logic [SCORE_W-1:0] score1_q, score1_d;
   logic [SCORE_W-1:0] score2_q, score2_d;
   logic               serve_dir_q, serve_dir_d;
   logic [1:0]         winner_q, winner_d;
   logic               reset_game_q;
   logic               ball_en_q;
   logic               timer_clear;
   logic               timer_done;
   logic [TICK_W-1:0]  timer_target;

   assign start_rise   = bus.start_btn && !start_q;
   assign timer_clear  = (state_d != state_q);
   assign timer_target = (state_q == ST_POINT) ? PAUSE_TGT : SERVE_TGT;

   tick_timer u_tick_timer (
      .clk    (clk),
      .reset  (reset),
      .clear  (timer_clear),
      .tick   (bus.frame_tick),
      .target (timer_target),
      .done   (timer_done)
   );

   // State register, registered outputs and start-button edge history.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         start_q      <= 1'b1;
         score1_q     <= '0;
         score2_q     <= '0;
         serve_dir_q  <= 1'b0;
         winner_q     <= 2'b00;
         reset_game_q <= 1'b1;
         ball_en_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         start_q      <= bus.start_btn;
         score1_q     <= score1_d;
         score2_q     <= score2_d;
         serve_dir_q  <= serve_dir_d;
         winner_q     <= winner_d;
         reset_game_q <= (state_d == ST_IDLE) || (state_d == ST_SERVE) || (state_d == ST_OVER);
         ball_en_q    <= (state_d == ST_PLAY);
      end
   end

   // Next-state and score decisions; unknown encodings recover to IDLE.
   always_comb begin
      state_d     = state_q;
      score1_d    = score1_q;
      score2_d    = score2_q;
      serve_dir_d = serve_dir_q;
      winner_d    = winner_q;
      case (state_q)
         ST_IDLE, ST_OVER: begin
            if (start_rise) begin
               state_d  = ST_SERVE;
               score1_d = '0;
               score2_d = '0;
               winner_d = 2'b00;
            end
         end
         ST_SERVE: begin
            if (timer_done) state_d = ST_PLAY;
         end
         ST_PLAY: begin
            if (bus.p1_miss && bus.p2_miss) begin
               state_d = ST_POINT;
            end else if (bus.p1_miss) begin
               state_d     = ST_POINT;
               score2_d    = score_inc(score2_q);
               serve_dir_d = 1'b0;
            end else if (bus.p2_miss) begin
               state_d     = ST_POINT;
               score1_d    = score_inc(score1_q);
               serve_dir_d = 1'b1;
            end
         end
         ST_POINT: begin
            if (timer_done) begin
               if (score1_q == WIN_S) begin
                  state_d  = ST_OVER;
                  winner_d = 2'b01;
               end else if (score2_q == WIN_S) begin
                  state_d  = ST_OVER;
                  winner_d = 2'b10;
               end else begin
                  state_d = ST_SERVE;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign bus.reset_game = reset_game_q;
   assign bus.ball_en    = ball_en_q;
   assign bus.serve_dir  = serve_dir_q;
   assign bus.score1     = score1_q;
   assign bus.score2     = score2_q;
   assign bus.winner     = winner_q;
   assign bus.state      = state_q;

endmodule

// File: tb/tb_game_controller.sv
// Self-checking bench for game_controller: a small spec-level model pushes
// expected output snapshots into a queue; each is popped and compared field
// by field once the DUT has clocked the stimulus.
module tb_game_controller;
   import pong_pkg::*;

   localparam int WIN   = 7;
   localparam int SERVE = 30;
   localparam int PAUSE = 60;

   logic clk;
   logic reset;
   int   checks;
   int   errors;

   // Snapshot layout: state[15:13] reset_game[12] ball_en[11] serve_dir[10]
   // score1[9:6] score2[5:2] winner[1:0]
   logic [15:0] exp_q[$];

   logic [2:0] e_state;
   logic [3:0] e_s1;
   logic [3:0] e_s2;
   logic       e_dir;
   logic [1:0] e_win;

   game_controller_if gif();

   game_controller #(
      .WIN_SCORE   (WIN),
      .SERVE_TICKS (SERVE),
      .PAUSE_TICKS (PAUSE)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (gif)
   );

   // Clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Watchdog
   initial begin
      #2000000;
      $display("FAIL watchdog: simulation still running, expected finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check_eq(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [15:0] model_snap();
      logic rg;
      logic be;
      rg = (e_state == 3'd0) || (e_state == 3'd1) || (e_state == 3'd4);
      be = (e_state == 3'd2);
      return {e_state, rg, be, e_dir, e_s1, e_s2, e_win};
   endfunction

   task automatic model_reset();
      e_state = 3'd0;
      e_s1    = 4'd0;
      e_s2    = 4'd0;
      e_dir   = 1'b0;
      e_win   = 2'b00;
   endtask

   task automatic compare_out(input string tag);
      logic [15:0] e;
      e = exp_q.pop_front();
      check_eq($sformatf("%s.state", tag),      16'(gif.state),      16'(e[15:13]));
      check_eq($sformatf("%s.reset_game", tag), 16'(gif.reset_game), 16'(e[12]));
      check_eq($sformatf("%s.ball_en", tag),    16'(gif.ball_en),    16'(e[11]));
      check_eq($sformatf("%s.serve_dir", tag),  16'(gif.serve_dir),  16'(e[10]));
      check_eq($sformatf("%s.score1", tag),     16'(gif.score1),     16'(e[9:6]));
      check_eq($sformatf("%s.score2", tag),     16'(gif.score2),     16'(e[5:2]));
      check_eq($sformatf("%s.winner", tag),     16'(gif.winner),     16'(e[1:0]));
   endtask

   // Push the model's expectation, clock the stimulus in, drop pulses, compare.
   task automatic clock_and_check(input string tag);
      exp_q.push_back(model_snap());
      @(posedge clk);
      #1;
      gif.frame_tick = 1'b0;
      gif.p1_miss    = 1'b0;
      gif.p2_miss    = 1'b0;
      compare_out(tag);
   endtask

   task automatic idle_cycles(input int n, input string tag);
      for (int i = 0; i < n; i++) clock_and_check(tag);
   endtask

   // Deliver n frame ticks with random gaps; the model moves on the last one.
   task automatic ticks_to(input int n, input logic [2:0] nxt, input logic [1:0] w, input string tag);
      for (int i = 0; i < n; i++) begin
         idle_cycles((i == 0) ? $urandom_range(1, 3) : $urandom_range(0, 2), tag);
         gif.frame_tick = 1'b1;
         if (i == n - 1) begin
            e_state = nxt;
            e_win   = w;
         end
         clock_and_check(tag);
      end
   endtask

   task automatic point_pause(input string tag);
      if (e_s1 == 4'(WIN))      ticks_to(PAUSE, 3'd4, 2'b01, tag);
      else if (e_s2 == 4'(WIN)) ticks_to(PAUSE, 3'd4, 2'b10, tag);
      else                      ticks_to(PAUSE, 3'd1, e_win, tag);
   endtask

   // Start button low then high; a frame tick rides on the rising cycle.
   task automatic press_start(input string tag);
      gif.start_btn = 1'b0;
      clock_and_check({tag, "_low"});
      gif.start_btn  = 1'b1;
      gif.frame_tick = 1'b1;
      if (e_state == 3'd0 || e_state == 3'd4) begin
         e_state = 3'd1;
         e_s1    = 4'd0;
         e_s2    = 4'd0;
         e_win   = 2'b00;
      end
      clock_and_check({tag, "_rise"});
   endtask

   task automatic miss_p1(input string tag);
      gif.p1_miss = 1'b1;
      e_s2    = (e_s2 == 4'hF) ? e_s2 : e_s2 + 4'd1;
      e_dir   = 1'b0;
      e_state = 3'd3;
      clock_and_check(tag);
   endtask

   task automatic miss_p2(input string tag);
      gif.p2_miss = 1'b1;
      e_s1    = (e_s1 == 4'hF) ? e_s1 : e_s1 + 4'd1;
      e_dir   = 1'b1;
      e_state = 3'd3;
      clock_and_check(tag);
   endtask

   initial begin
      checks = 0;
      errors = 0;
      gif.frame_tick = 1'b0;
      gif.start_btn  = 1'b1;
      gif.p1_miss    = 1'b0;
      gif.p2_miss    = 1'b0;
      reset = 1'b1;
      model_reset();

      // Reset state, button held high through reset
      repeat (2) @(posedge clk);
      #1;
      exp_q.push_back(model_snap());
      compare_out("reset");
      reset = 1'b0;
      idle_cycles(2, "held_btn");

      // Start, serve, play
      press_start("start");
      ticks_to(SERVE, 3'd2, e_win, "serve1");

      // Start edges in PLAY are ignored
      press_start("play_start");

      // p2 misses: point to player 1
      miss_p2("p2_miss");
      gif.p1_miss = 1'b1;
      clock_and_check("point_miss_ignored");
      point_pause("pause1");

      // Misses in SERVE are ignored
      gif.p1_miss = 1'b1;
      clock_and_check("serve_p1_ignored");
      gif.p2_miss = 1'b1;
      clock_and_check("serve_p2_ignored");
      ticks_to(SERVE, 3'd2, e_win, "serve2");

      // Simultaneous misses: no score, direction holds
      gif.p1_miss    = 1'b1;
      gif.p2_miss    = 1'b1;
      gif.frame_tick = 1'b1;
      e_state = 3'd3;
      clock_and_check("both_miss");
      point_pause("pause2");
      ticks_to(SERVE, 3'd2, e_win, "serve3");

      // Seven points to player 2 ends the game
      for (int k = 0; k < WIN; k++) begin
         miss_p1($sformatf("p1_miss%0d", k));
         point_pause($sformatf("pause_p%0d", k));
         if (e_state == 3'd1) ticks_to(SERVE, 3'd2, e_win, $sformatf("serve_p%0d", k));
      end
      idle_cycles(3, "over_hold");
      gif.p2_miss = 1'b1;
      clock_and_check("over_miss_ignored");

      // Restart from OVER
      press_start("restart");
      ticks_to(SERVE, 3'd2, e_win, "serve4");
      miss_p2("p2_miss_b");
      ticks_to(10, 3'd3, e_win, "partial_pause");

      // Asynchronous reset mid-POINT takes effect before the next edge
      #3;
      reset = 1'b1;
      model_reset();
      exp_q.push_back(model_snap());
      #1;
      compare_out("reset_mid_point");
      clock_and_check("reset_held");
      reset = 1'b0;
      idle_cycles(2, "post_reset");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/game_controller.md
GAME_CONTROLLER -- requirements
Module: game_controller

Interface
REQ-001 The block SHALL have parameter WIN_SCORE, default 7, meaning points to win (legal range 1..15).
REQ-002 The block SHALL have parameter SERVE_TICKS, default 30, meaning frame ticks spent in SERVE.
REQ-003 The block SHALL have parameter PAUSE_TICKS, default 60, meaning frame ticks spent in POINT (legal range 1..255).
REQ-004 clk  input  1  single system clock; all logic on its rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 frame_tick  input  1  one-cycle pulse, once per video frame.
REQ-007 start_btn  input  1  level, already synchronised to clk; the block detects its rising edge internally.
REQ-008 p1_miss  input  1  one-cycle pulse; ball passed the left (player 1) edge.
REQ-009 p2_miss  input  1  one-cycle pulse; ball passed the right (player 2) edge.
REQ-010 reset_game  output  1  drives paddle_movement and ball logic; 1 = recentre paddles and ball.
REQ-011 ball_en  output  1  1 = ball logic may advance.
REQ-012 serve_dir  output  1  0 = serve toward player 1, 1 = serve toward player 2.
REQ-013 score1, score2  output  4 each  player scores.
REQ-014 winner  output  2  00 = none, 01 = player 1, 10 = player 2.
REQ-015 state  output  3  current FSM state encoding, for debug.

Function
REQ-016 All outputs SHALL be registered; each responds in the cycle after the input event that causes it.
REQ-017 States and encodings SHALL be IDLE=0, SERVE=1, PLAY=2, POINT=3, OVER=4; any other encoding SHALL go to IDLE on the next clock.
REQ-018 In IDLE, reset_game=1, ball_en=0 and scores hold; a start_btn rising edge SHALL clear the scores and winner and move to SERVE.
REQ-019 In SERVE, reset_game=1 and ball_en=0; on the SERVE_TICKS-th frame_tick after entry the FSM SHALL move to PLAY.
REQ-020 In PLAY, reset_game=0 and ball_en=1.
REQ-021 In PLAY, p1_miss alone SHALL increment score2, set serve_dir=0 and move to POINT.
REQ-022 In PLAY, p2_miss alone SHALL increment score1, set serve_dir=1 and move to POINT.
REQ-023 If p1_miss and p2_miss are asserted in the same cycle, neither score SHALL change, serve_dir SHALL hold, and the FSM SHALL move to POINT.
REQ-024 In POINT, reset_game=0 (paddles hold position) and ball_en=0.
REQ-025 On the PAUSE_TICKS-th frame_tick in POINT, the FSM SHALL move to OVER if either score equals WIN_SCORE, otherwise to SERVE.
REQ-026 On entry to OVER, winner SHALL be set to the player whose score equals WIN_SCORE.
REQ-027 In OVER, reset_game=1 and ball_en=0; a start_btn rising edge SHALL clear the scores and winner and move to SERVE.
REQ-028 Miss pulses outside PLAY SHALL be ignored.
REQ-029 start_btn edges outside IDLE and OVER SHALL be ignored.
REQ-030 Scores SHALL saturate at 15.
REQ-031 The tick counter SHALL be 8 bits, SHALL clear on every state entry, and SHALL count only frame_tick pulses.
REQ-032 A frame_tick arriving in the same cycle as a state entry SHALL NOT be counted.

Reset
REQ-033 Asserting reset SHALL immediately force: state=IDLE, reset_game=1, ball_en=0, serve_dir=0, score1=score2=0, winner=00, tick counter=0, start edge-detect history=1 (so a button held through reset does not start a game).
REQ-034 Reset asserted mid-PLAY or mid-POINT SHALL discard any pending score without an update.

Structure
REQ-035 Package pong_pkg SHALL hold the state encoding, the score width (4) and the tick-counter width (8); it is shared with the ball logic.
REQ-036 A single sub-module tick_timer SHALL implement the clearable counter of frame_tick pulses with a terminal-count compare.

Verification
REQ-037 The bench SHALL cover: reset, then a start_btn rise -> SERVE next cycle; after 30 frame_ticks -> PLAY with ball_en=1, reset_game=0.
REQ-038 The bench SHALL cover: p2_miss in PLAY -> score1=1, serve_dir=1, POINT; after 60 ticks -> SERVE.
REQ-039 The bench SHALL cover: p1_miss and p2_miss in the same cycle -> scores unchanged, POINT.
REQ-040 The bench SHALL cover: seven p1_miss points -> score2=7; after the POINT pause -> OVER with winner=10, reset_game=1; a start_btn rise -> scores 0, SERVE.
REQ-041 The bench SHALL cover: reset asserted mid-POINT -> IDLE, scores 0, winner 00 within the same cycle.
REQ-042 The bench SHALL cover: miss pulses in SERVE and start_btn edges in PLAY -> no change in state or scores.
